// File: rtl/eth_csr_pkg.sv
// eth_csr_pkg: shared FSM states and response constants for the MAC CSR bridge
package eth_csr_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  localparam int TO_CNT_W = 8;
  localparam logic [127:0] TIMEOUT_RDATA = '1;
  localparam logic [127:0] ILLEGAL_RDATA = '0;
endpackage

// File: rtl/eth_csr_timeout_ctr.sv
// eth_csr_timeout_ctr: clearable cycle counter; expired marks the TIMEOUT_CYC-th counted cycle
module eth_csr_timeout_ctr #(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYC + 1);
  logic [W-1:0] cnt;
  assign expired = en && cnt == W'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/eth_mac_csr_bridge.sv
// eth_mac_csr_bridge: single-command bridge to NUM_ETH Avalon-MM MAC CSR ports with timeout.
// Optional broadcast writes enabled by defining ETH_CSR_BCAST_WR_EN.
module eth_mac_csr_bridge
  import eth_csr_pkg::*;
#(
  parameter int NUM_ETH = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYC = 1023,
  localparam int PSEL_W = (NUM_ETH > 1) ? $clog2(NUM_ETH) : 1
) (
  input  logic                      prmgmt_ctrl_clk,
  input  logic                      prmgmt_arst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic                      cmd_bcast,
  input  logic [PSEL_W-1:0]         cmd_port,
  input  logic [ADDR_W-1:0]         cmd_addr,
  input  logic [DATA_W-1:0]         cmd_wdata,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [TO_CNT_W-1:0]       timeout_cnt,
  output logic [NUM_ETH-1:0]        mac_read,
  output logic [NUM_ETH-1:0]        mac_write,
  output logic [ADDR_W-1:0]         mac_address,
  output logic [DATA_W-1:0]         mac_writedata,
  input  logic [NUM_ETH*DATA_W-1:0] mac_readdata,
  input  logic [NUM_ETH-1:0]        mac_waitrequest
);
  state_t state;
  logic [PSEL_W-1:0] port;
  logic wr, bc, illegal, done, expired;
  logic [NUM_ETH-1:0] oh;
  logic [DATA_W-1:0] sel_rdata;
`ifdef ETH_CSR_BCAST_WR_EN
  assign bc = cmd_bcast & cmd_write;
`else
  assign bc = 1'b0 & cmd_bcast;
`endif
  assign illegal = int'(cmd_port) >= NUM_ETH;
  assign oh = NUM_ETH'(1) << cmd_port;
  // Each strobe falls as its port accepts; the access is done once none would remain.
  assign done = ~|((mac_read | mac_write) & mac_waitrequest);
  assign sel_rdata = mac_readdata[int'(port)*DATA_W +: DATA_W];
  eth_csr_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_to (
    .clk(prmgmt_ctrl_clk),
    .rst(prmgmt_arst),
    .clr(state == IDLE),
    .en(state == ISSUE),
    .expired(expired)
  );
  always_ff @(posedge prmgmt_ctrl_clk or posedge prmgmt_arst)
    if (prmgmt_arst) begin
      state <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      busy <= 1'b0;
      timeout_cnt <= '0;
      mac_read <= '0;
      mac_write <= '0;
      mac_address <= '0;
      mac_writedata <= '0;
      port <= '0;
      wr <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (state == IDLE) begin
        if (cmd_valid) begin
          cmd_ready <= 1'b0;
          wr <= cmd_write;
          port <= cmd_port;
          mac_address <= cmd_addr;
          mac_writedata <= cmd_wdata;
          if (illegal && !bc) begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_err <= 1'b1;
            rsp_rdata <= ILLEGAL_RDATA[DATA_W-1:0];
          end else begin
            state <= ISSUE;
            busy <= 1'b1;
            mac_read <= cmd_write ? '0 : oh;
            mac_write <= cmd_write ? (bc ? '1 : oh) : '0;
          end
        end
      end else if (state == ISSUE) begin
        mac_read <= mac_read & mac_waitrequest;
        mac_write <= mac_write & mac_waitrequest;
        if (done || expired) begin
          state <= RESP;
          busy <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err <= !done;
          rsp_rdata <= !done ? TIMEOUT_RDATA[DATA_W-1:0] : wr ? '0 : sel_rdata;
          mac_read <= '0;
          mac_write <= '0;
          if (!done) timeout_cnt <= timeout_cnt + TO_CNT_W'(timeout_cnt != '1);
        end
      end else begin
        state <= IDLE;
        cmd_ready <= 1'b1;
      end
    end
endmodule
